// File: rtl/shift_reg_seq_if.sv
// Request-side handshake between a transfer requester and the shift-register sequencer.
interface shift_reg_seq_if;
  logic       start;
  logic       mode;
  logic [7:0] din;
  logic       rx_in;
  logic       abort;
  logic       busy;
  logic       done;

  modport master (
    output start, mode, din, rx_in, abort,
    input  busy, done
  );

  modport slave (
    input  start, mode, din, rx_in, abort,
    output busy, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequencer driving op/data/serial_in of an 8-bit shift register through one
// complete TX (load then shift out) or RX (clear then shift in) transfer.
module shift_reg_seq #(
  parameter int          NBITS    = 8,
  parameter int          DIV      = 1,
  parameter logic [2:0]  OP_HOLD  = 3'b000,
  parameter logic [2:0]  OP_LOAD  = 3'b001,
  parameter logic [2:0]  OP_SHIFT = 3'b010
) (
  input  logic            clk,
  input  logic            rst,
  shift_reg_seq_if.slave  req,
  output logic [2:0]      sr_op,
  output logic [7:0]      sr_data,
  output logic            sr_serial_in
);

  localparam int                CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(NBITS);
  localparam logic [15:0]       DIV_LAST = (DIV > 1) ? 16'(DIV - 2) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [15:0]       div_cnt, div_cnt_nx;
  logic              mode_r, mode_nx;
  logic [7:0]        din_r, din_nx;
  logic [2:0]        op_nx;
  logic [7:0]        data_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    mode_nx    = mode_r;
    din_nx     = din_r;

    unique case (state)
      S_IDLE: begin
        if (req.start) begin
          state_nx = S_LOAD;
          mode_nx  = req.mode;
          din_nx   = req.din;
        end
      end
      S_LOAD: begin
        bit_cnt_nx = '0;
        div_cnt_nx = '0;
        state_nx   = (DIV > 1) ? S_WAIT : S_SHIFT;
      end
      S_WAIT: begin
        div_cnt_nx = div_cnt + 16'd1;
        if (div_cnt == DIV_LAST) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        bit_cnt_nx = bit_cnt + 1'b1;
        div_cnt_nx = '0;
        if (bit_cnt_nx == BIT_LAST) state_nx = S_DONE;
        else                        state_nx = (DIV > 1) ? S_WAIT : S_SHIFT;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort only cancels a transfer in flight; the register keeps whatever it holds.
    if (req.abort && (state inside {S_LOAD, S_WAIT, S_SHIFT})) state_nx = S_IDLE;

    // Outputs are computed for the state being entered so they are registered with it.
    op_nx   = OP_HOLD;
    data_nx = sr_data;
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
    case (state_nx)
      S_LOAD: begin
        op_nx   = OP_LOAD;
        data_nx = mode_nx ? 8'h00 : din_nx;
      end
      S_SHIFT: op_nx = OP_SHIFT;
      default: op_nx = OP_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      mode_r  <= 1'b0;
      sr_op   <= OP_HOLD;
      sr_data <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      mode_r  <= mode_nx;
      sr_op   <= op_nx;
      sr_data <= data_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    din_r <= din_nx;
  end

  assign req.busy     = busy_r;
  assign req.done     = done_r;
  assign sr_serial_in = mode_r ? req.rx_in : 1'b0;

endmodule
